// File: rtl/draw_sprite_scaled_pkg.sv
// Shared definitions for the scaled sprite overlay stage.
// Contents:
//   TIMING_W      width of the packed VGA timing bundle (hcount/hsync/hblnk/vcount/vsync/vblnk)
//   RGB_W         colour width (4:4:4)
//   KEY_COLOR_DEF default transparent colour
//   timing_t      packed timing bundle carried alongside the pixel data
//   calc_addr_w() address width needed to index an image of n pixels
package draw_sprite_scaled_pkg;

  localparam int TIMING_W = 12 + 1 + 1 + 12 + 1 + 1;
  localparam int RGB_W    = 12;

  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;

  typedef struct packed {
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  function automatic int calc_addr_w(input int n_pixels);
    return (n_pixels <= 2) ? 1 : $clog2(n_pixels);
  endfunction

endpackage

// File: rtl/draw_sprite_scaled_sig_delay.sv
// Fixed-depth shift register used to carry data through the ROM read latency.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset, clears every stage
//   data     WIDTH-bit input word
//   delayed  data delayed by DEPTH clock cycles (DEPTH >= 1)
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= data;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign delayed = line_q[DEPTH-1];

endmodule

// File: rtl/draw_sprite_scaled.sv
// Scaled sprite overlay for the VGA pipeline.
// Draws an IMG_W x IMG_H sprite read from an external synchronous ROM at a
// per-frame latched (xpos, ypos), magnified by 2**SCALE_SHIFT, with optional
// colour-key transparency and clipping at the 4095 edge of the count space.
// Ports:
//   pclk, rst                 pixel clock, asynchronous active-low reset
//   enable                    draw sprite when 1 (latched at vblnk rise)
//   xpos, ypos                sprite top-left corner (latched at vblnk rise)
//   hcount_in..vblnk_in       incoming timing
//   rgb_in                    background colour
//   rgb_pixel                 ROM data, ROM_LAT cycles after pixel_addr
//   pixel_addr                ROM address
//   hcount_out..vblnk_out     timing delayed by ROM_LAT+1 cycles
//   rgb_out                   composited colour, same delay as the timing
module draw_sprite_scaled
  import draw_sprite_scaled_pkg::*;
#(
  parameter int               IMG_W       = 48,
  parameter int               IMG_H       = 64,
  parameter int               ADDR_W      = 12,
  parameter int               SCALE_SHIFT = 0,
  parameter int               ROM_LAT     = 1,
  parameter int               KEY_EN      = 1,
  parameter logic [RGB_W-1:0] KEY_COLOR   = KEY_COLOR_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [11:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [11:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [11:0]       hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [11:0]       vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam logic [12:0] SPR_W = 13'(IMG_W << SCALE_SHIFT);
  localparam logic [12:0] SPR_H = 13'(IMG_H << SCALE_SHIFT);
  localparam int          IDX_W = calc_addr_w(IMG_W * IMG_H);
  localparam int          DLY_W = TIMING_W + RGB_W + 1;

  function automatic logic is_key(input logic [RGB_W-1:0] px);
    return (KEY_EN != 0) && (px == KEY_COLOR);
  endfunction

  // Frame latch: position and enable only change on the vblnk rising edge,
  // so a sprite never tears within a frame.
  logic        vblnk_prev;
  logic [11:0] xpos_q;
  logic [11:0] ypos_q;
  logic        enable_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_prev <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      enable_q   <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xpos_q   <= xpos;
        ypos_q   <= ypos;
        enable_q <= enable;
      end
    end
  end

  // Region test and address arithmetic. The 13-bit differences keep the
  // comparisons free of wrap, so a sprite near 4095 is clipped, and a
  // negative offset (left of / above the sprite) never matches.
  logic [12:0]      dx, dy, col, row;
  logic             hit;
  logic [IDX_W-1:0] idx;

  always_comb begin
    dx  = {1'b0, hcount_in} - {1'b0, xpos_q};
    dy  = {1'b0, vcount_in} - {1'b0, ypos_q};
    col = dx >> SCALE_SHIFT;
    row = dy >> SCALE_SHIFT;
    hit = !hblnk_in && !vblnk_in && enable_q &&
          (hcount_in >= xpos_q) && (vcount_in >= ypos_q) &&
          (dx < SPR_W) && (dy < SPR_H);
    idx = IDX_W'(32'(row) * IMG_W + 32'(col));
  end

  // ---- stage p0: address issue, timing/background captured ----
  timing_t          timing_p0;
  logic [RGB_W-1:0] rgb_p0;
  logic             in_area_p0;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      timing_p0  <= '0;
      rgb_p0     <= '0;
      in_area_p0 <= 1'b0;
      pixel_addr <= '0;
    end else begin
      timing_p0  <= '{hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
      rgb_p0     <= rgb_in;
      in_area_p0 <= hit;
      // Outside the sprite the address is left alone to avoid needless ROM toggling.
      if (hit) pixel_addr <= ADDR_W'(idx);
    end
  end

  // ---- stage p1: ROM_LAT cycles, aligned with rgb_pixel ----
  logic [DLY_W-1:0] dly_data, dly_q;
  timing_t          timing_p1;
  logic [RGB_W-1:0] rgb_p1;
  logic             in_area_p1;

  assign dly_data = {timing_p0, rgb_p0, in_area_p0};

  sig_delay #(
    .WIDTH (DLY_W),
    .DEPTH (ROM_LAT)
  ) u_rom_align (
    .clk     (pclk),
    .rst     (rst),
    .data    (dly_data),
    .delayed (dly_q)
  );

  assign {timing_p1, rgb_p1, in_area_p1} = dly_q;

  assign hcount_out = timing_p1.hcount;
  assign hsync_out  = timing_p1.hsync;
  assign hblnk_out  = timing_p1.hblnk;
  assign vcount_out = timing_p1.vcount;
  assign vsync_out  = timing_p1.vsync;
  assign vblnk_out  = timing_p1.vblnk;

  // Composite from the aligned p1 registers and the registered ROM output,
  // keeping rgb on exactly the same ROM_LAT+1 delay as the timing outputs.
  always_comb begin
    rgb_out = rgb_p1;
    if (timing_p1.hblnk || timing_p1.vblnk) begin
      rgb_out = '0;
    end else if (in_area_p1 && !is_key(rgb_pixel)) begin
      rgb_out = rgb_pixel;
    end
  end

endmodule

// File: tb/tb_draw_sprite_scaled.sv
// Directed bench for draw_sprite_scaled. Three instances share the inputs:
//   dut_a defaults (scale 1, ROM_LAT 1, key on)
//   dut_b SCALE_SHIFT=1, ROM_LAT=2
//   dut_c KEY_EN=0
// Each has a ROM model whose word equals its address, except address 5 = 12'hF0F.
module tb_draw_sprite_scaled;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst, enable;
  logic [11:0] xpos, ypos, hcount_in, vcount_in, rgb_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;

  logic [11:0] addr_a, pix_a, hc_a, vc_a, rgb_a;
  logic        hs_a, hb_a, vs_a, vb_a;
  logic [11:0] addr_b, pix_b, rom_b1, hc_b, vc_b, rgb_b;
  logic        hs_b, hb_b, vs_b, vb_b;
  logic [11:0] addr_c, pix_c, hc_c, vc_c, rgb_c;
  logic        hs_c, hb_c, vs_c, vb_c;

  int n_vec = 0;
  int n_bad = 0;

  draw_sprite_scaled dut_a (
    .pclk(pclk), .rst(rst), .enable(enable), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(pix_a), .pixel_addr(addr_a),
    .hcount_out(hc_a), .hsync_out(hs_a), .hblnk_out(hb_a),
    .vcount_out(vc_a), .vsync_out(vs_a), .vblnk_out(vb_a), .rgb_out(rgb_a)
  );

  draw_sprite_scaled #(.SCALE_SHIFT(1), .ROM_LAT(2)) dut_b (
    .pclk(pclk), .rst(rst), .enable(enable), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(pix_b), .pixel_addr(addr_b),
    .hcount_out(hc_b), .hsync_out(hs_b), .hblnk_out(hb_b),
    .vcount_out(vc_b), .vsync_out(vs_b), .vblnk_out(vb_b), .rgb_out(rgb_b)
  );

  draw_sprite_scaled #(.KEY_EN(0)) dut_c (
    .pclk(pclk), .rst(rst), .enable(enable), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(pix_c), .pixel_addr(addr_c),
    .hcount_out(hc_c), .hsync_out(hs_c), .hblnk_out(hb_c),
    .vcount_out(vc_c), .vsync_out(vs_c), .vblnk_out(vb_c), .rgb_out(rgb_c)
  );

  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return (a == 12'd5) ? 12'hF0F : a;
  endfunction

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pix_a  <= '0;
      rom_b1 <= '0;
      pix_b  <= '0;
      pix_c  <= '0;
    end else begin
      pix_a  <= rom_word(addr_a);
      rom_b1 <= rom_word(addr_b);
      pix_b  <= rom_b1;
      pix_c  <= rom_word(addr_c);
    end
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    chk64(tag, 64'(obs), 64'(exp));
  endtask

  task automatic put(input logic [11:0] h, input logic [11:0] v,
                     input logic hb, input logic vb, input logic [11:0] c);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hb;
    vsync_in  = vb;
    rgb_in    = c;
  endtask

  task automatic settle;
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic latch_frame(input logic [11:0] x, input logic [11:0] y, input logic en);
    xpos   = x;
    ypos   = y;
    enable = en;
    put(12'd0, 12'd0, 1'b1, 1'b1, 12'h000);
    settle;
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b1;
    xpos = 12'd0;
    ypos = 12'd0;
    put(12'd0, 12'd0, 1'b0, 1'b0, 12'hABC);

    // Reset held with active, changing inputs: everything stays 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk);
      #1;
      chk64("reset_a_outputs", {24'd0, hc_a, vc_a, hs_a, hb_a, vs_a, vb_a, rgb_a}, 64'd0);
      chk12("reset_a_addr", addr_a, 12'h000);
      chk12("reset_b_rgb", rgb_b, 12'h000);
      put(12'(i * 7 + 3), 12'(i), 1'b0, 1'b0, 12'(i + 1));
    end

    // Release during blanking, then one non-blank pixel: appears after
    // exactly 2 cycles on dut_a and 3 cycles on dut_b (passthrough, enable_q=0).
    put(12'd0, 12'd0, 1'b1, 1'b0, 12'h555);
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk12("refill_blank", rgb_a, 12'h000);
    put(12'd0, 12'd0, 1'b0, 1'b0, 12'h555);
    @(posedge pclk); #1;
    chk12("latency_a_early", rgb_a, 12'h000);
    @(posedge pclk); #1;
    chk12("latency_a_exact", rgb_a, 12'h555);
    chk12("latency_b_early", rgb_b, 12'h000);
    @(posedge pclk); #1;
    chk12("latency_b_exact", rgb_b, 12'h555);

    // Frame 1: sprite at (100,50).
    latch_frame(12'd100, 12'd50, 1'b1);
    put(12'd100, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_origin", rgb_a, 12'h000);
    chk12("place_origin_c", rgb_c, 12'h000);
    chk12("hcount_delay", hc_a, 12'd100);
    chk12("vcount_delay", vc_a, 12'd50);
    put(12'd147, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_right_col", rgb_a, 12'h02F);
    chk12("place_addr", addr_a, 12'd47);
    put(12'd148, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_past_right", rgb_a, 12'h321);
    chk12("addr_hold", addr_a, 12'd47);
    put(12'd100, 12'd51, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_row1", rgb_a, 12'h030);
    put(12'd99, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_left_out", rgb_a, 12'h321);
    put(12'd100, 12'd49, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_above_out", rgb_a, 12'h321);
    put(12'd147, 12'd113, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_last", rgb_a, 12'hBFF);
    put(12'd100, 12'd114, 1'b0, 1'b0, 12'h321); settle;
    chk12("place_below_out", rgb_a, 12'h321);
    put(12'd105, 12'd50, 1'b0, 1'b0, 12'h123); settle;
    chk12("key_transparent", rgb_a, 12'h123);
    chk12("key_disabled", rgb_c, 12'hF0F);
    put(12'd110, 12'd60, 1'b1, 1'b0, 12'h321); settle;
    chk12("hblnk_in_sprite", rgb_a, 12'h000);
    chk12("hblnk_out", {11'd0, hb_a}, 12'd1);
    chk12("hsync_out", {11'd0, hs_a}, 12'd1);

    // Mid-frame position change must not move the sprite yet.
    xpos = 12'd4070;
    put(12'd147, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("midframe_old_pos", rgb_a, 12'h02F);
    put(12'd4080, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("midframe_new_ignored", rgb_a, 12'h321);

    // Frame 2: sprite at (4070,50), clipped at 4095, no wrap to hcount 0.
    latch_frame(12'd4070, 12'd50, 1'b1);
    put(12'd4070, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("clip_origin", rgb_a, 12'h000);
    put(12'd4095, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("clip_edge", rgb_a, 12'h019);
    put(12'd4095, 12'd113, 1'b0, 1'b0, 12'h321); settle;
    chk12("clip_edge_last_row", rgb_a, 12'hBE9);
    put(12'd0, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("clip_no_wrap", rgb_a, 12'h321);
    put(12'd4069, 12'd50, 1'b0, 1'b0, 12'h321); settle;
    chk12("clip_left_out", rgb_a, 12'h321);

    // Frame 3: sprite at (0,0); dut_b doubles every pixel.
    latch_frame(12'd0, 12'd0, 1'b1);
    put(12'd0, 12'd0, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_0_0", rgb_b, 12'h000);
    put(12'd1, 12'd0, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_1_0", rgb_b, 12'h000);
    put(12'd0, 12'd1, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_0_1", rgb_b, 12'h000);
    put(12'd1, 12'd1, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_1_1", rgb_b, 12'h000);
    put(12'd2, 12'd0, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_2_0", rgb_b, 12'h001);
    chk12("unscaled_2_0", rgb_a, 12'h002);
    put(12'd95, 12'd0, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_right", rgb_b, 12'h02F);
    put(12'd96, 12'd0, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_past_right", rgb_b, 12'h321);
    put(12'd0, 12'd127, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_bottom", rgb_b, 12'hBD0);
    put(12'd0, 12'd128, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_past_bottom", rgb_b, 12'h321);
    put(12'd95, 12'd127, 1'b0, 1'b0, 12'h321); settle;
    chk12("scale_last", rgb_b, 12'hBFF);

    // Frame 4: enable latched low, pure delayed passthrough.
    latch_frame(12'd0, 12'd0, 1'b0);
    put(12'd0, 12'd0, 1'b0, 1'b0, 12'h456); settle;
    chk12("disabled_origin", rgb_a, 12'h456);
    put(12'd10, 12'd10, 1'b0, 1'b0, 12'h456); settle;
    chk12("disabled_inside_b", rgb_b, 12'h456);
    put(12'd20, 12'd20, 1'b0, 1'b0, 12'h111); settle;
    put(12'd20, 12'd20, 1'b0, 1'b0, 12'h222);
    @(posedge pclk); #1;
    chk12("disabled_latency_early", rgb_a, 12'h111);
    @(posedge pclk); #1;
    chk12("disabled_latency_exact", rgb_a, 12'h222);
    put(12'd5, 12'd5, 1'b1, 1'b0, 12'h456); settle;
    chk12("disabled_blank", rgb_a, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_sprite_scaled.md
Name: draw_sprite_scaled

Overview:
- Parametrised successor of the fixed-size rectangle/image overlay stage in the VGA pipeline.
- Overlays an IMG_W x IMG_H sprite, fetched from an external synchronous ROM, at a frame-latched (xpos, ypos).
- Adds integer power-of-two scaling, colour-key transparency, right/bottom clipping, a configurable ROM latency and an enable input.
- Sits between the background generator and the next overlay/output stage. Forwards all timing signals with a fixed delay.

Parameters:
- IMG_W, 48, sprite width in pixels.
- IMG_H, 64, sprite height in pixels.
- ADDR_W, 12, pixel_addr width; IMG_W*IMG_H <= 2**ADDR_W.
- SCALE_SHIFT, 0, scale = 2**SCALE_SHIFT; legal range 0..3.
- ROM_LAT, 1, ROM read latency in pclk cycles; legal range 1..2.
- KEY_EN, 1, 1 enables colour-key transparency.
- KEY_COLOR, 12'hF0F, transparent colour.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = draw sprite, 0 = pass rgb_in through.
- xpos  in  12  sprite left edge; sampled once per frame.
- ypos  in  12  sprite top edge; sampled once per frame.
- hcount_in  in  12  horizontal count.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  12  vertical count.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  background colour.
- rgb_pixel  in  12  ROM data, valid ROM_LAT cycles after pixel_addr.
- pixel_addr  out  ADDR_W  ROM address.
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  12/1/1/12/1/1  delayed timing.
- rgb_out  out  12  composited colour.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, all delay-line stages 0, latched position 0, vblnk edge detector 0.
- Position latch: xpos_q/ypos_q and enable_q load on the cycle vblnk_in goes 0->1. Mid-frame changes take effect in the next frame (no tearing).
- Stage A (registered, 1 cycle):
  - dx = hcount_in - xpos_q and dy = vcount_in - ypos_q, both computed 13-bit.
  - in_area = !hblnk_in && !vblnk_in && hcount_in >= xpos_q && vcount_in >= ypos_q && dx < (IMG_W<<SCALE_SHIFT) && dy < (IMG_H<<SCALE_SHIFT) && enable_q.
  - Region edge sums use 13-bit arithmetic, so a sprite near 4095 clips instead of wrapping.
  - pixel_addr = (dy>>SCALE_SHIFT)*IMG_W + (dx>>SCALE_SHIFT), truncated to ADDR_W.
  - pixel_addr holds its previous value when !in_area.
- Stages B..: in_area, rgb_in and all timing signals are delayed ROM_LAT further cycles, aligned with rgb_pixel.
- Output register:
  - Blank (hblnk or vblnk delayed): rgb_out = 12'h000.
  - Else if in_area_d && !(KEY_EN && rgb_pixel == KEY_COLOR): rgb_out = rgb_pixel.
  - Else: rgb_out = rgb_in_d.
- Total latency, input to every output: ROM_LAT + 1 cycles, identical for timing and rgb.
- Pixel at (xpos_q, ypos_q) shows ROM address 0. Each ROM pixel repeats 2**SCALE_SHIFT times horizontally and vertically.
- xpos_q > 4095 - scaled width: right part clipped; same rule applies vertically.
- Latch update on a cycle with active video cannot occur because vblnk is high during the update.
- rst asserted mid-line: outputs go to 0 immediately. After release the pipeline refills; the first valid output appears ROM_LAT+1 cycles later. Position stays 0 until the next vblnk rise.
- enable low: rgb_out = blank ? 0 : rgb_in_d, from the next frame.

Decomposition:
- Shared package holds:
  - Timing-bundle width constant: 12+1+1+12+1+1 = 28 bits.
  - Colour width RGB_W = 12.
  - Default KEY_COLOR.
  - Function computing ADDR_W from IMG_W*IMG_H.
- One sub-module: sig_delay.
  - Parameters WIDTH, DEPTH.
  - Asynchronous active-low reset shift register.
  - Used for the timing bundle, rgb_in and in_area through the ROM_LAT stages.

Test Plan:
- Reset:
  - Stimulus: rst low for 5 cycles, toggling inputs.
  - Required: all outputs 0 throughout; first non-zero rgb_out exactly ROM_LAT+1 cycles after the first non-blank input.
- Placement:
  - Stimulus: xpos=100, ypos=50, SCALE_SHIFT=0, ROM model data = address.
  - Required: at output (100,50) rgb_out=0; at (147,50) rgb_out=47; at (100,51) rgb_out=48; at (148,50) rgb_out=rgb_in.
- Scaling:
  - Stimulus: SCALE_SHIFT=1, xpos=0, ypos=0.
  - Required: pixels (0,0),(1,0),(0,1),(1,1) all show address 0; (2,0) shows 1; the sprite covers 96x128 pixels.
- Transparency:
  - Stimulus: ROM address 5 returns 12'hF0F, rgb_in=12'h123.
  - Required: rgb_out=12'h123 at that pixel. With KEY_EN=0, rgb_out=12'hF0F.
- Frame latch and clipping:
  - Stimulus: change xpos from 100 to 4070 mid-frame.
  - Required: the current frame is still drawn at 100. The next frame is drawn at 4070, the sprite is clipped at 4095, and there is no wrap at hcount 0.
- Blanking/enable:
  - Stimulus: hblnk high inside the sprite region.
  - Required: rgb_out=0.
  - Stimulus: enable=0 latched.
  - Required: rgb_out=rgb_in delayed by ROM_LAT+1 cycles for the whole frame.
